// File: rtl/beta_pkg.sv
// Shared constants and types for the beta core front end.
package beta_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] BETA_BOOT_ADDR = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/beta_fetch_fifo.sv
// Small circular buffer with synchronous flush; serves both as the instruction
// buffer and as the in-order PC tag queue of in-flight requests.
module beta_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage holds data only and is never reset.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
endmodule

// File: rtl/beta_fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches tagged with their PC,
// buffers responses for the decoder and drains stale responses after a redirect.
module beta_fetch_unit
   import beta_pkg::*;
#(
   parameter logic [XLEN-1:0] BOOT_ADDR  = BETA_BOOT_ADDR,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            misaligned_o
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_t      state;
   logic [XLEN-1:0]   fetch_pc;
   logic [CW-1:0]     fifo_count;
   logic [CW-1:0]     outstanding;
   logic [CW:0]       inflight;
   logic [CW:0]       outstanding_next;
   logic [XLEN-1:0]   tag_pc;
   logic [2*XLEN-1:0] fifo_head;
   logic              redirect;
   logic              grant;
   logic              rsp;
   logic              fifo_push;
   logic              fifo_pop;

   assign redirect  = redirect_i && (state != BOOT);
   assign grant     = imem_req_o && imem_gnt_i;
   assign rsp       = imem_rvalid_i && (state != BOOT) && (outstanding != '0);
   assign fifo_push = rsp && (state == FETCH) && !redirect;
   assign fifo_pop  = instr_valid_o && instr_ready_i && !redirect;

   // Requests are throttled so every in-flight response always has a buffer slot.
   assign inflight         = {1'b0, outstanding} + {1'b0, fifo_count};
   assign outstanding_next = {1'b0, outstanding} + (CW+1)'(grant) - (CW+1)'(rsp);

   assign imem_req_o    = (state == FETCH) && (inflight < (CW+1)'(FIFO_DEPTH));
   assign imem_addr_o   = fetch_pc;
   assign instr_valid_o = (fifo_count != '0);
   assign instr_o       = fifo_head[2*XLEN-1:XLEN];
   assign instr_pc_o    = fifo_head[XLEN-1:0];

   // Its occupancy is the outstanding-request count; only reset abandons entries.
   beta_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
      .clk   (clk_i),
      .rstn  (rstn_i),
      .flush (1'b0),
      .push  (grant),
      .wdata (fetch_pc),
      .pop   (rsp),
      .rdata (tag_pc),
      .count (outstanding)
   );

   beta_fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_instr_q (
      .clk   (clk_i),
      .rstn  (rstn_i),
      .flush (redirect),
      .push  (fifo_push),
      .wdata ({imem_rdata_i, tag_pc}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .count (fifo_count)
   );

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state        <= BOOT;
         fetch_pc     <= BOOT_ADDR;
         misaligned_o <= 1'b0;
      end else begin
         misaligned_o <= redirect && (redirect_pc_i[1:0] != 2'b00);
         unique case (state)
            BOOT: state <= FETCH;
            FETCH, FLUSH: begin
               if (redirect) begin
                  fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
                  state    <= (outstanding_next != '0) ? FLUSH : FETCH;
               end else begin
                  if (grant) fetch_pc <= fetch_pc + XLEN'(4);
                  if ((state == FLUSH) && (outstanding_next == '0)) state <= FETCH;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end
endmodule

// File: doc/beta_fetch_unit.md
BETA_FETCH_UNIT -- requirements
Module: beta_fetch_unit

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries, and also the maximum number of outstanding requests; legal values are 2 and 4.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port imem_req_o, output, 1 bit: memory fetch request.
REQ-006 SHALL have port imem_addr_o, output, XLEN bits: request word address.
REQ-007 SHALL have port imem_gnt_i, input, 1 bit: request accepted this cycle.
REQ-008 SHALL have port imem_rvalid_i, input, 1 bit: response data valid.
REQ-009 SHALL have port imem_rdata_i, input, XLEN bits: response instruction word.
REQ-010 SHALL have port instr_o, output, XLEN bits: instruction to the decoder's instr_i.
REQ-011 SHALL have port instr_pc_o, output, XLEN bits: address of instr_o.
REQ-012 SHALL have port instr_valid_o, output, 1 bit: instr_o holds a valid instruction.
REQ-013 SHALL have port instr_ready_i, input, 1 bit: decoder consumes instr_o.
REQ-014 SHALL have port redirect_i, input, 1 bit: jump, branch or trap taken.
REQ-015 SHALL have port redirect_pc_i, input, XLEN bits: new fetch target.
REQ-016 SHALL have port misaligned_o, output, 1 bit: one-cycle pulse when a redirect target is not word-aligned.

Function
REQ-017 SHALL implement an FSM with states BOOT, FETCH and FLUSH, encoded with the type fetch_state_t.
REQ-018 BOOT SHALL last exactly one cycle after reset release and then go to FETCH; imem_req_o SHALL be 0 in BOOT.
REQ-019 In FETCH, imem_req_o SHALL be 1 when (outstanding count + FIFO count) < FIFO_DEPTH.
REQ-020 imem_addr_o SHALL equal fetch_pc; while a request is not granted, imem_req_o and imem_addr_o SHALL stay stable.
REQ-021 When imem_req_o and imem_gnt_i are both 1: fetch_pc SHALL advance by 4, wrapping modulo 2^XLEN with no error; the outstanding count SHALL increment; the granted address SHALL be pushed into an in-order PC tag queue.
REQ-022 When imem_rvalid_i is 1 in FETCH: imem_rdata_i and the oldest tag SHALL be written into the instruction FIFO, and the outstanding count SHALL decrement.
REQ-023 Responses SHALL return in order; the minimum latency is 1 cycle after grant.
REQ-024 instr_o, instr_pc_o and instr_valid_o SHALL come from the FIFO head; instr_valid_o SHALL equal 1 when the FIFO is not empty.
REQ-025 When instr_valid_o and instr_ready_i are both 1, the FIFO SHALL pop.
REQ-026 A push and a pop in the same cycle SHALL both take effect; the FIFO count SHALL be unchanged.
REQ-027 Write and read pointers SHALL wrap at FIFO_DEPTH.
REQ-028 FIFO full SHALL never coincide with a response, by construction of REQ-019; the bench SHALL assert this.
REQ-029 redirect_i=1 in any state except BOOT SHALL, on the next edge:
- flush the FIFO (instr_valid_o=0 in the following cycle);
- set fetch_pc to {redirect_pc_i[XLEN-1:2], 2'b00};
- go to FLUSH if outstanding is non-zero after this cycle's grant/response accounting, otherwise go to FETCH.
REQ-030 redirect_i SHALL take priority over instr_ready_i, imem_rvalid_i and FIFO pushes in the same cycle.
REQ-031 misaligned_o SHALL pulse for 1 cycle, registered, when redirect_i=1 and redirect_pc_i[1:0]!=0.
REQ-032 In FLUSH:
- imem_req_o SHALL be 0;
- each imem_rvalid_i SHALL be discarded and SHALL decrement the outstanding count;
- on reaching zero, the FSM SHALL go to FETCH.
REQ-033 A new redirect in FLUSH SHALL update fetch_pc and remain in FLUSH.
REQ-034 Fetch latency from redirect (no outstanding requests, immediate grant, 1-cycle memory) to instr_valid_o SHALL be 3 cycles.

Reset
REQ-035 With rstn_i=0 at a clock edge, the block SHALL enter BOOT with:
- fetch_pc=BOOT_ADDR;
- FIFO and tag queue empty, pointers 0;
- outstanding=0;
- imem_req_o=0, instr_valid_o=0, misaligned_o=0.
REQ-036 Reset asserted mid-transaction SHALL abandon outstanding requests; responses arriving during BOOT SHALL be ignored; the memory side SHALL be reset together with this block.

Structure
REQ-037 fetch_state_t SHALL be defined in beta_pkg, next to XLEN.
REQ-038 The default BOOT_ADDR SHALL come from BETA_BOOT_ADDR in beta_pkg.
REQ-039 The instruction FIFO SHALL be a sub-module beta_fetch_fifo, parameterised by WIDTH=2*XLEN and DEPTH; it is reused for the tag queue.
REQ-040 The block SHALL contain no combinational path from imem_rdata_i to instr_o.

Verification
REQ-041 The bench SHALL cover:
- Reset release with gnt=1, 1-cycle memory -> first request addr 0x0 at cycle 2; instr_valid_o at cycle 4 with instr_pc_o=0x0; subsequent PCs 0x4, 0x8.
- instr_ready_i held 0 -> at most 2 requests issued (FIFO_DEPTH=2), imem_req_o drops to 0, no data lost; after ready=1, instructions arrive in order.
- redirect_pc_i=0x100 with 2 requests outstanding -> FLUSH; 2 responses discarded; next request addr 0x100; no stale instr_valid_o.
- redirect_pc_i=0x102 -> misaligned_o pulses once; fetch resumes at 0x100.
- fetch_pc=0xFFFF_FFFC granted -> next request addr 0x0000_0000.
- redirect_i and instr_ready_i in the same cycle as imem_rvalid_i -> response dropped; instr_valid_o=0 next cycle.
